sw_debounce_sync: RTL and testbench
===================================

Name: sw_debounce_sync

Overview:
Upstream conditioning stage for the 16 board slide switches ahead of the serial LED shifter.
- Synchronises the raw switch inputs into Clk_100M and debounces each bit independently.
- Publishes a clean 16-bit snapshot, sw_stable, which drives the LED shifter's sw input.
- Rate-limits snapshot updates so the downstream 17-cycle serial shift always completes before the next change.

Parameters:
DB_CYCLES, 1000000, consecutive cycles a synchronised bit must disagree with its debounced value before being accepted (10 ms at 100 MHz); legal minimum 2
CNT_W, 20, width of each per-bit debounce counter; must satisfy 2^CNT_W > DB_CYCLES
HOLDOFF, 20, minimum cycles between sw_update pulses; must be >= 17 (downstream shift length)

Ports:
Clk_100M  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-low reset
sw_raw  input  16  asynchronous raw switch levels
sw_stable  output  16  published debounced switch vector, registered
sw_update  output  1  one-cycle pulse, high in the cycle sw_stable takes a new value
busy  output  1  high while the holdoff window is active (HOLD state)

Behaviour:
Interface: reset is synchronous, active-low; the clock is Clk_100M.

Reset (reset==0 at a clock edge):
- Synchroniser flops, debounced vector db, and all counters clear to 0.
- sw_stable=16'h0, sw_update=0, busy=0; FSM enters IDLE.
- Reset asserted mid-debounce or mid-holdoff abandons all progress. No pulse is emitted on reset exit unless db later differs from 0.

Synchroniser:
- Two flops per bit (s1, s2), no combinational path from sw_raw.

Per-bit debounce (i = 0..15):
- If s2[i]==db[i]: cnt[i] <= 0.
- Else if cnt[i]==DB_CYCLES-1: db[i] <= s2[i] and cnt[i] <= 0.
- Else: cnt[i] <= cnt[i]+1.
- A glitch shorter than DB_CYCLES synchronised cycles never changes db.
- Bits are fully independent; simultaneous acceptance on several bits is allowed.

Publisher FSM:
- IDLE, db != sw_stable: sw_stable <= db, sw_update <= 1, hcnt <= HOLDOFF-1, go to HOLD.
- IDLE, db == sw_stable: sw_update <= 0, stay in IDLE.
- HOLD: sw_update <= 0, busy=1.
  - If hcnt==0, go to IDLE.
  - Else hcnt <= hcnt-1.
- db changes during HOLD are deferred, not lost. The first IDLE cycle publishes the latest db, so multiple changes coalesce into one pulse.
- If db returns to the old sw_stable value before IDLE, no pulse is emitted.
- Spacing between consecutive sw_update pulses is at least HOLDOFF+1 cycles.

Latency:
- A clean raw step on an idle block: sw_stable and sw_update are visible after clock edge DB_CYCLES+3, counted from the first edge that samples the new level.
- Breakdown: 2 sync edges + DB_CYCLES accept edges + 1 publish edge.

Width rules:
- Counters are unsigned and never wrap; saturation is impossible by construction.
- sw_stable is exactly the db register value; bits are not inverted.

Test Plan:
(Benches use DB_CYCLES=8, HOLDOFF=20.)
1. Reset: hold reset=0 for 3 cycles with sw_raw=16'hFFFF -> sw_stable=0, sw_update=0, busy=0 throughout reset.
2. Clean step: after reset, sw_raw 0->16'hA5C3 -> sw_stable=16'hA5C3 with a single sw_update pulse at edge 11, then busy=1 for 20 cycles.
3. Glitch rejection: bit 3 high for 7 cycles, then low -> no sw_update and sw_stable unchanged; repeat with 8 cycles -> bit 3 accepted (sw_stable=16'h0008).
4. Coalescing: sw_raw=16'h0001, then 16'h0003 accepted during HOLD, then 16'h0007 -> second pulse only after busy falls, carrying 16'h0007; pulse spacing >= 21 cycles.
5. Bounce: bit 15 toggles every 3 cycles for 40 cycles, then settles high -> exactly one update, to 16'h8000, DB_CYCLES+3 edges after the final transition.
6. Reset mid-holdoff: assert reset while busy=1 with db=16'h00F0 -> all outputs 0; after release with sw_raw=16'h00F0, a fresh pulse arrives at edge 11.

Source files
------------

// File: rtl/sw_debounce_sync.sv
// Switch conditioning: two-flop synchroniser, per-bit debounce, and a rate-limited
// publisher that spaces sw_update pulses so the downstream serial shift always completes.
//
// state | meaning
// IDLE  | waiting; publishes db as soon as it differs from sw_stable
// HOLD  | holdoff window after a publish; db changes are deferred until IDLE
module sw_debounce_sync #(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20,
  parameter int HOLDOFF   = 20
) (
  input  logic        Clk_100M,
  input  logic        reset,
  input  logic [15:0] sw_raw,
  output logic [15:0] sw_stable,
  output logic        sw_update,
  output logic        busy
);

  localparam int HCNT_W = $clog2(HOLDOFF);
  localparam logic [CNT_W-1:0]  DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [HCNT_W-1:0] H_LAST  = HCNT_W'(HOLDOFF - 1);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  logic [15:0]       s1;
  logic [15:0]       s2;
  logic [15:0]       db;
  logic [CNT_W-1:0]  cnt [16];

  state_t            state;
  state_t            state_nxt;
  logic [HCNT_W-1:0] hcnt;
  logic [HCNT_W-1:0] hcnt_nxt;
  logic [15:0]       stable_nxt;
  logic              update_nxt;

  always_ff @(posedge Clk_100M) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // Each bit restarts its count whenever the synchronised level agrees with db,
  // so only an uninterrupted run of DB_CYCLES disagreeing samples is accepted.
  always_ff @(posedge Clk_100M) begin
    if (!reset) begin
      db <= '0;
      for (int i = 0; i < 16; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk_100M) begin
    if (!reset) begin
      state     <= IDLE;
      hcnt      <= '0;
      sw_stable <= '0;
      sw_update <= 1'b0;
    end else begin
      state     <= state_nxt;
      hcnt      <= hcnt_nxt;
      sw_stable <= stable_nxt;
      sw_update <= update_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    hcnt_nxt   = hcnt;
    stable_nxt = sw_stable;
    update_nxt = 1'b0;
    case (state)
      IDLE: begin
        // Comparing against sw_stable (not the previous db) lets changes that
        // revert during HOLD vanish and several changes coalesce into one pulse.
        if (db != sw_stable) begin
          stable_nxt = db;
          update_nxt = 1'b1;
          hcnt_nxt   = H_LAST;
          state_nxt  = HOLD;
        end
      end
      HOLD: begin
        if (hcnt == '0) begin
          state_nxt = IDLE;
        end else begin
          hcnt_nxt = hcnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state == HOLD);

endmodule

// File: tb/tb_sw_debounce_sync.sv
// Bench for sw_debounce_sync: expected publish events (value, cycle) are queued as
// stimulus is applied and popped by a monitor whenever sw_update fires.
module tb_sw_debounce_sync;

  localparam int DB_CYCLES = 8;
  localparam int CNT_W     = 4;
  localparam int HOLDOFF   = 20;
  localparam int LAT       = DB_CYCLES + 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw_raw;
  logic [15:0] sw_stable;
  logic        sw_update;
  logic        busy;

  typedef struct {
    logic [15:0] val;
    int          at;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   last_pulse = -1000;
  int   n_cmp = 0;
  int   n_mis = 0;

  sw_debounce_sync #(
    .DB_CYCLES(DB_CYCLES),
    .CNT_W    (CNT_W),
    .HOLDOFF  (HOLDOFF)
  ) dut (
    .Clk_100M (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .sw_stable(sw_stable),
    .sw_update(sw_update),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Scoreboard monitor: every pulse must match the head of the queue.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      last_pulse = -1000;
    end else if (sw_update === 1'b1) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_pulse: sw_stable=%h at cycle %0d, required no pulse", sw_stable, cyc);
      end else begin
        e = q.pop_front();
        if (sw_stable !== e.val) begin
          n_mis++;
          $display("FAIL pulse_value: got %h, required %h (cycle %0d)", sw_stable, e.val, cyc);
        end
        n_cmp++;
        if (cyc !== e.at) begin
          n_mis++;
          $display("FAIL pulse_cycle: got %0d, required %0d", cyc, e.at);
        end
      end
      n_cmp++;
      if (cyc - last_pulse < HOLDOFF + 1) begin
        n_mis++;
        $display("FAIL pulse_spacing: got %0d, required >= %0d", cyc - last_pulse, HOLDOFF + 1);
      end
      last_pulse = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic wait_pulse(input int lim, input string name);
    int n;
    n = 0;
    while (sw_update !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (sw_update !== 1'b1) begin
      n_mis++;
      $display("FAIL %s_timeout: no sw_update within %0d cycles, required a pulse", name, lim);
    end
  endtask

  task automatic end_check(input string name);
    repeat (40) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_mis++;
      $display("FAIL %s_pending: %0d expected pulses never seen, required 0", name, q.size());
    end
    q.delete();
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    sw_raw = 16'h0000;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset  = 1'b0;
    sw_raw = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (sw_stable !== 16'h0000) begin
        n_mis++;
        $display("FAIL reset_sw_stable: got %h, required 0000", sw_stable);
      end
      n_cmp++;
      if (sw_update !== 1'b0) begin
        n_mis++;
        $display("FAIL reset_sw_update: got %b, required 0", sw_update);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
        n_mis++;
        $display("FAIL reset_busy: got %b, required 0", busy);
      end
    end
    sw_raw = 16'h0000;
    reset  = 1'b1;
    end_check("reset_exit");
  endtask

  task automatic test_clean_step();
    int n;
    sw_raw = 16'hA5C3;
    q.push_back('{16'hA5C3, cyc + LAT});
    wait_pulse(40, "clean_step");
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n !== HOLDOFF) begin
      n_mis++;
      $display("FAIL busy_length: got %0d cycles, required %0d", n, HOLDOFF);
    end
    n_cmp++;
    if (sw_stable !== 16'hA5C3) begin
      n_mis++;
      $display("FAIL clean_step_hold: got %h, required a5c3", sw_stable);
    end
    end_check("clean_step");
  endtask

  task automatic test_glitch();
    int c;
    do_reset();
    sw_raw = 16'h0008;
    repeat (DB_CYCLES - 1) @(negedge clk);
    sw_raw = 16'h0000;
    repeat (30) @(negedge clk);
    n_cmp++;
    if (sw_stable !== 16'h0000) begin
      n_mis++;
      $display("FAIL glitch_short: got %h, required 0000", sw_stable);
    end
    // An exactly DB_CYCLES-long pulse is accepted; its release is accepted in
    // HOLD and published on the first IDLE cycle.
    c = cyc;
    sw_raw = 16'h0008;
    q.push_back('{16'h0008, c + LAT});
    q.push_back('{16'h0000, c + LAT + HOLDOFF + 1});
    repeat (DB_CYCLES) @(negedge clk);
    sw_raw = 16'h0000;
    wait_pulse(20, "glitch_accept");
    @(negedge clk);
    wait_pulse(40, "glitch_release");
    end_check("glitch");
  endtask

  task automatic test_coalesce();
    int p;
    do_reset();
    sw_raw = 16'h0001;
    q.push_back('{16'h0001, cyc + LAT});
    wait_pulse(40, "coalesce_first");
    p = cyc;
    sw_raw = 16'h0003;
    q.push_back('{16'h0007, p + HOLDOFF + 1});
    repeat (3) @(negedge clk);
    sw_raw = 16'h0007;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_mis++;
      $display("FAIL coalesce_busy: got %b, required 1", busy);
    end
    @(negedge clk);
    wait_pulse(60, "coalesce_second");
    end_check("coalesce");
  endtask

  task automatic test_bounce();
    do_reset();
    for (int k = 0; k < 14; k++) begin
      sw_raw = (k % 2 == 0) ? 16'h8000 : 16'h0000;
      repeat (3) @(negedge clk);
    end
    sw_raw = 16'h8000;
    q.push_back('{16'h8000, cyc + LAT});
    wait_pulse(40, "bounce");
    end_check("bounce");
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    sw_raw = 16'h00F0;
    q.push_back('{16'h00F0, cyc + LAT});
    wait_pulse(40, "midhold_first");
    repeat (5) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_mis++;
      $display("FAIL midhold_busy: got %b, required 1", busy);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({sw_stable, sw_update, busy} !== 18'h0) begin
      n_mis++;
      $display("FAIL midhold_reset: got sw_stable=%h sw_update=%b busy=%b, required all 0",
               sw_stable, sw_update, busy);
    end
    @(negedge clk);
    reset = 1'b1;
    q.push_back('{16'h00F0, cyc + LAT});
    wait_pulse(40, "midhold_fresh");
    end_check("midhold");
  endtask

  initial begin
    reset  = 1'b0;
    sw_raw = 16'hFFFF;
    test_reset();
    test_clean_step();
    test_glitch();
    test_coalesce();
    test_bounce();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
